procb_core_sched: RTL and testbench

//  Scheduler for process_bytes core input. Sequences procb_thread_addr by driving its set_next_* strobes.

---
 rtl/procb_core_sched.sv | 143 ++++++++++++++
 tb/tb_procb_core_sched.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/procb_core_sched.sv
// Round-robin scheduler feeding process_bytes cores from procb_buf, one block per serviceable slot.
// Drives the procb_thread_addr set_next_* strobes and mirrors its core_ctx_num as slot_idx.
module procb_core_sched #(
  parameter int unsigned N_CORES       = 4,
  parameter int unsigned N_CORES_MSB   = ($clog2(N_CORES) > 0) ? $clog2(N_CORES) - 1 : 0,
  parameter int unsigned BLK_WORDS     = 16,
  parameter int unsigned BLK_WORDS_MSB = ($clog2(BLK_WORDS) > 0) ? $clog2(BLK_WORDS) - 1 : 0,
  parameter int unsigned PREFETCH_LAT  = 2
) (
  input  logic                     CLK,
  input  logic                     reset,
  input  logic [2*N_CORES-1:0]     core_ctx_ready,
  input  logic                     procb_data_valid,
  input  logic                     procb_last_block,
  output logic                     set_next_core_ctx_num,
  output logic                     set_next_seq_num,
  output logic                     set_next_procb_rd_thread_num,
  output logic                     buf_rd_en,
  output logic [BLK_WORDS_MSB:0]   buf_rd_addr,
  output logic                     core_wr_en,
  output logic [BLK_WORDS_MSB:0]   core_wr_addr,
  output logic                     core_start,
  output logic [N_CORES_MSB+1:0]   slot_idx
);

  localparam int unsigned N_SLOTS = 2 * N_CORES;
  localparam int unsigned SLOT_W  = N_CORES_MSB + 2;
  localparam int unsigned ADDR_W  = BLK_WORDS_MSB + 1;
  localparam int unsigned WAIT_W  = (PREFETCH_LAT > 1) ? $clog2(PREFETCH_LAT) : 1;

  typedef enum logic [2:0] {
    S_WAIT,
    S_CHECK,
    S_XFER,
    S_FLUSH,
    S_START,
    S_ADVANCE
  } state_t;

  state_t              state, state_nxt;
  logic [WAIT_W-1:0]   wait_cnt, wait_cnt_nxt;
  logic                last_r, last_nxt;
  logic [ADDR_W-1:0]   rd_addr_nxt;
  logic                rd_en_nxt;
  logic                start_nxt;
  logic                seq_nxt;
  logic                adv_nxt;

  // Configuration-time value only; reset must not disturb alignment with procb_thread_addr.
  logic [SLOT_W-1:0]   slot_q = '0;

  assign slot_idx = slot_q;

  // State and registered outputs
  always_ff @(posedge CLK) begin
    if (reset) begin
      state                        <= S_WAIT;
      wait_cnt                     <= '0;
      last_r                       <= 1'b0;
      buf_rd_en                    <= 1'b0;
      buf_rd_addr                  <= '0;
      core_wr_en                   <= 1'b0;
      core_wr_addr                 <= '0;
      core_start                   <= 1'b0;
      set_next_seq_num             <= 1'b0;
      set_next_core_ctx_num        <= 1'b0;
      set_next_procb_rd_thread_num <= 1'b0;
    end else begin
      state                        <= state_nxt;
      wait_cnt                     <= wait_cnt_nxt;
      last_r                       <= last_nxt;
      buf_rd_en                    <= rd_en_nxt;
      buf_rd_addr                  <= rd_addr_nxt;
      core_wr_en                   <= buf_rd_en;
      core_wr_addr                 <= buf_rd_addr;
      core_start                   <= start_nxt;
      set_next_seq_num             <= seq_nxt;
      set_next_core_ctx_num        <= adv_nxt;
      set_next_procb_rd_thread_num <= adv_nxt;
    end
  end

  // Follows the strobe itself, so a reset landing on S_ADVANCE still tracks procb_thread_addr
  always_ff @(posedge CLK) begin
    if (set_next_core_ctx_num) begin
      slot_q <= (slot_q == SLOT_W'(N_SLOTS - 1)) ? '0 : slot_q + SLOT_W'(1);
    end
  end

  // Next state and next registered output values
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    last_nxt     = last_r;
    rd_addr_nxt  = '0;

    case (state)
      S_WAIT: begin
        if (wait_cnt == WAIT_W'(PREFETCH_LAT - 1)) begin
          state_nxt    = S_CHECK;
          wait_cnt_nxt = '0;
        end else begin
          wait_cnt_nxt = wait_cnt + WAIT_W'(1);
        end
      end
      S_CHECK: begin
        if (core_ctx_ready[slot_q] && procb_data_valid) begin
          state_nxt = S_XFER;
          last_nxt  = procb_last_block;
        end else begin
          state_nxt = S_ADVANCE;
        end
      end
      S_XFER: begin
        if (buf_rd_addr == ADDR_W'(BLK_WORDS - 1)) begin
          state_nxt = S_FLUSH;
        end else begin
          rd_addr_nxt = buf_rd_addr + ADDR_W'(1);
        end
      end
      S_FLUSH:   state_nxt = S_START;
      S_START:   state_nxt = S_ADVANCE;
      S_ADVANCE: state_nxt = S_WAIT;
      default:   state_nxt = S_WAIT;
    endcase

    rd_en_nxt = (state_nxt == S_XFER);
    start_nxt = (state_nxt == S_START);
    seq_nxt   = start_nxt && last_nxt;
    adv_nxt   = (state_nxt == S_ADVANCE);
  end

  // Seq write must land on the serviced slot, before core_ctx_num moves on
  a_seq_not_with_adv: assert property (@(posedge CLK) disable iff (reset)
    !(set_next_seq_num && set_next_core_ctx_num));

  a_wr_follows_rd: assert property (@(posedge CLK) disable iff (reset)
    buf_rd_en |=> core_wr_en);

  a_start_after_xfer: assert property (@(posedge CLK) disable iff (reset)
    core_start |-> !buf_rd_en && !core_wr_en);

endmodule

// File: tb/tb_procb_core_sched.sv
// Bench for procb_core_sched: per-cycle timeline model of each slot visit plus directed scenario checks.
module tb_procb_core_sched;

  localparam int NC = 2;
  localparam int BW = 4;
  localparam int PL = 2;
  localparam int NS = 2 * NC;

  logic       CLK;
  logic       reset;
  logic [3:0] core_ctx_ready;
  logic       procb_data_valid;
  logic       procb_last_block;
  logic       set_next_core_ctx_num;
  logic       set_next_seq_num;
  logic       set_next_procb_rd_thread_num;
  logic       buf_rd_en;
  logic [1:0] buf_rd_addr;
  logic       core_wr_en;
  logic [1:0] core_wr_addr;
  logic       core_start;
  logic [1:0] slot_idx;

  logic [3:0] last_sel;

  int n_chk  = 0;
  int n_fail = 0;

  // model: cycle offset within the current slot visit
  int m_t    = 0;
  int m_slot = 0;
  bit m_svc  = 1'b0;
  bit m_last = 1'b0;
  bit m_ok   = 1'b0;

  int          cyc = 0;
  int          cnt_rd, cnt_wr, cnt_start, cnt_seq, cnt_adv, prev_adv, sp_min, sp_max;
  int          cnt_overlap = 0;
  logic [15:0] slot_seq;
  logic [3:0]  start_mask, seq_mask;
  logic [3:0]  seq_bit = 4'b0000;

  procb_core_sched #(
    .N_CORES(NC),
    .BLK_WORDS(BW),
    .PREFETCH_LAT(PL)
  ) dut (
    .CLK(CLK),
    .reset(reset),
    .core_ctx_ready(core_ctx_ready),
    .procb_data_valid(procb_data_valid),
    .procb_last_block(procb_last_block),
    .set_next_core_ctx_num(set_next_core_ctx_num),
    .set_next_seq_num(set_next_seq_num),
    .set_next_procb_rd_thread_num(set_next_procb_rd_thread_num),
    .buf_rd_en(buf_rd_en),
    .buf_rd_addr(buf_rd_addr),
    .core_wr_en(core_wr_en),
    .core_wr_addr(core_wr_addr),
    .core_start(core_start),
    .slot_idx(slot_idx)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always_comb procb_last_block = last_sel[slot_idx];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_counters();
    cnt_rd = 0; cnt_wr = 0; cnt_start = 0; cnt_seq = 0; cnt_adv = 0;
    prev_adv = -1; sp_min = 1000; sp_max = 0;
    slot_seq = '0; start_mask = '0; seq_mask = '0;
  endtask

  task automatic run_adv(input int n, input string name);
    int k;
    k = 0;
    while (cnt_adv < n && k < 300) begin
      @(negedge CLK);
      k++;
    end
    chk({name, " slot strobes"}, cnt_adv, n);
  endtask

  task automatic wait_rd(input string name);
    int k;
    k = 0;
    while (!buf_rd_en && k < 100) begin
      @(negedge CLK);
      k++;
    end
    chk({name, " xfer seen"}, int'(buf_rd_en), 1);
  endtask

  // Model update on each edge, then compare and tally DUT events just after it
  always @(posedge CLK) begin
    bit adv, e_rd, e_wr, e_start, e_seq, e_adv;
    adv = m_ok && (m_svc ? (m_t == PL + BW + 3) : (m_t == PL + 1));
    if (adv) m_slot = (m_slot + 1) % NS;
    if (reset) begin
      m_t = 0; m_svc = 1'b0; m_ok = 1'b1;
    end else if (adv) begin
      m_t = 0; m_svc = 1'b0;
    end else begin
      if (m_t == PL) begin
        m_svc  = core_ctx_ready[m_slot] && procb_data_valid;
        m_last = last_sel[m_slot];
      end
      m_t++;
    end
    #1;
    cyc++;
    if (m_ok) begin
      e_rd    = m_svc && (m_t >= PL + 1) && (m_t <= PL + BW);
      e_wr    = m_svc && (m_t >= PL + 2) && (m_t <= PL + BW + 1);
      e_start = m_svc && (m_t == PL + BW + 2);
      e_seq   = e_start && m_last;
      e_adv   = m_svc ? (m_t == PL + BW + 3) : (m_t == PL + 1);
      chk("buf_rd_en", int'(buf_rd_en), int'(e_rd));
      if (e_rd) chk("buf_rd_addr", int'(buf_rd_addr), m_t - PL - 1);
      chk("core_wr_en", int'(core_wr_en), int'(e_wr));
      if (e_wr) chk("core_wr_addr", int'(core_wr_addr), m_t - PL - 2);
      chk("core_start", int'(core_start), int'(e_start));
      chk("set_next_seq_num", int'(set_next_seq_num), int'(e_seq));
      chk("set_next_core_ctx_num", int'(set_next_core_ctx_num), int'(e_adv));
      chk("set_next_procb_rd_thread_num", int'(set_next_procb_rd_thread_num), int'(e_adv));
      chk("slot_idx", int'(slot_idx), m_slot);
    end
    if (buf_rd_en) cnt_rd++;
    if (core_wr_en) cnt_wr++;
    if (core_start) begin
      cnt_start++;
      start_mask[slot_idx] = 1'b1;
    end
    if (set_next_seq_num) begin
      cnt_seq++;
      seq_mask[slot_idx] = 1'b1;
      seq_bit[slot_idx]  = ~seq_bit[slot_idx];
    end
    if (set_next_seq_num && set_next_core_ctx_num) cnt_overlap++;
    if (set_next_core_ctx_num) begin
      cnt_adv++;
      slot_seq = {slot_seq[13:0], slot_idx};
      if (prev_adv >= 0) begin
        if (cyc - prev_adv < sp_min) sp_min = cyc - prev_adv;
        if (cyc - prev_adv > sp_max) sp_max = cyc - prev_adv;
      end
      prev_adv = cyc;
    end
  end

  initial begin
    reset            = 1'b1;
    core_ctx_ready   = 4'b1111;
    procb_data_valid = 1'b1;
    last_sel         = 4'b0000;
    clear_counters();
    repeat (3) @(negedge CLK);
    chk("reset buf_rd_en", int'(buf_rd_en), 0);
    chk("reset core_wr_en", int'(core_wr_en), 0);
    chk("reset core_start", int'(core_start), 0);
    chk("reset ctx strobe", int'(set_next_core_ctx_num), 0);
    chk("reset seq strobe", int'(set_next_seq_num), 0);
    chk("reset slot_idx", int'(slot_idx), 0);
    reset = 1'b0;
    clear_counters();

    // all slots serviced, full round plus wrap
    run_adv(5, "t1");
    chk("t1 rd cycles", cnt_rd, 20);
    chk("t1 wr cycles", cnt_wr, 20);
    chk("t1 starts", cnt_start, 5);
    chk("t1 seq strobes", cnt_seq, 0);
    chk("t1 slot order", int'(slot_seq[9:0]), 'h06C);
    chk("t1 min spacing", sp_min, 10);
    chk("t1 max spacing", sp_max, 10);
    chk("t1 start mask", int'(start_mask), 'hF);

    // only slot 2 ready
    core_ctx_ready = 4'b0100;
    clear_counters();
    run_adv(4, "t2");
    chk("t2 rd cycles", cnt_rd, 4);
    chk("t2 wr cycles", cnt_wr, 4);
    chk("t2 starts", cnt_start, 1);
    chk("t2 start mask", int'(start_mask), 'h4);
    chk("t2 slot order", int'(slot_seq[7:0]), 'h6C);
    chk("t2 min spacing", sp_min, 4);
    chk("t2 max spacing", sp_max, 10);

    // last block on slot 1 only
    core_ctx_ready = 4'b1111;
    last_sel       = 4'b0010;
    clear_counters();
    run_adv(4, "t3");
    chk("t3 starts", cnt_start, 4);
    chk("t3 seq strobes", cnt_seq, 1);
    chk("t3 seq mask", int'(seq_mask), 'h2);
    chk("t3 seq bits", int'(seq_bit), 'h2);
    chk("t3 min spacing", sp_min, 10);

    // no data anywhere
    last_sel         = 4'b0000;
    procb_data_valid = 1'b0;
    clear_counters();
    run_adv(4, "t4");
    chk("t4 rd cycles", cnt_rd, 0);
    chk("t4 wr cycles", cnt_wr, 0);
    chk("t4 starts", cnt_start, 0);
    chk("t4 slot order", int'(slot_seq[7:0]), 'h6C);
    chk("t4 min spacing", sp_min, 4);
    chk("t4 max spacing", sp_max, 4);

    // reset on the second transfer cycle, then retry
    procb_data_valid = 1'b1;
    clear_counters();
    wait_rd("t5");
    @(negedge CLK);
    reset = 1'b1;
    @(negedge CLK);
    chk("t5 rd_en after reset", int'(buf_rd_en), 0);
    chk("t5 wr_en after reset", int'(core_wr_en), 0);
    chk("t5 slot kept", int'(slot_idx), 1);
    chk("t5 aborted starts", cnt_start, 0);
    chk("t5 aborted strobes", cnt_adv, 0);
    chk("t5 aborted seq", cnt_seq, 0);
    reset = 1'b0;
    clear_counters();
    run_adv(1, "t5");
    chk("t5 retry starts", cnt_start, 1);
    chk("t5 retry start mask", int'(start_mask), 'h2);
    chk("t5 retry rd cycles", cnt_rd, 4);
    chk("t5 retry wr cycles", cnt_wr, 4);
    chk("t5 retry slot", int'(slot_seq[1:0]), 1);

    // ready and valid vanish mid-transfer
    clear_counters();
    wait_rd("t6");
    core_ctx_ready   = 4'b0000;
    procb_data_valid = 1'b0;
    run_adv(1, "t6");
    chk("t6 rd cycles", cnt_rd, 4);
    chk("t6 wr cycles", cnt_wr, 4);
    chk("t6 starts", cnt_start, 1);
    chk("t6 start mask", int'(start_mask), 'h4);
    chk("t6 slot", int'(slot_seq[1:0]), 2);

    repeat (12) @(negedge CLK);
    chk("seq/ctx overlap", cnt_overlap, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
